// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of the single register-file write port.
// One requester is granted per cycle. The winning write is registered onto
// RegWrite/write_reg/write_data. Writes to $zero are accepted and discarded,
// and each discarded write bumps a saturating counter.
module regfile_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic [$clog2(N_REQ)-1:0]  rr_ptr,
    output logic [CNT_W-1:0]          zero_drop_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  zcnt_q, zcnt_d;

    logic [N_REQ-1:0]  grant;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    int unsigned       idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Rotating priority search starting at rr_ptr; ready is one-hot and forced low in reset or hold.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (rst_n && !hold) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = (32'(rr_ptr_q) + k) % N_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx[PTR_W-1:0];
                end
            end
        end
    end

    assign req_ready = grant;
    assign win_addr  = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    assign win_data  = req_data[32'(grant_idx)*DATA_W +: DATA_W];

    // Next-state for the write port, pointer and $zero-drop counter.
    always_comb begin
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        rr_ptr_d     = rr_ptr_q;
        zcnt_d       = zcnt_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (win_addr != '0) begin
                regwrite_d   = 1'b1;
                write_reg_d  = win_addr;
                write_data_d = win_data;
            end else if (zcnt_q != '1) begin
                zcnt_d = zcnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            rr_ptr_q     <= '0;
            zcnt_q       <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            rr_ptr_q     <= rr_ptr_d;
            zcnt_q       <= zcnt_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign write_reg     = write_reg_q;
    assign write_data    = write_data_q;
    assign rr_ptr        = rr_ptr_q;
    assign zero_drop_cnt = zcnt_q;

endmodule
